// File: rtl/add_tree_mult_sim_if.sv
// Operand and display bundle for the add-tree multiplier demo block.
// The master side drives the operands; the slave side returns the product and display signals.
interface add_tree_mult_sim_if;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic [19:0] p_BCD;
    logic [3:0]  scan_data_1;
    logic        scan_en_1;
    logic [3:0]  scan_data_0;
    logic [3:0]  scan_en_0;
    logic [6:0]  data_1_7seg;
    logic [6:0]  data_0_7seg;

    modport master (
        output a, b,
        input  p, p_BCD, scan_data_1, scan_en_1, scan_data_0, scan_en_0,
               data_1_7seg, data_0_7seg
    );

    modport slave (
        input  a, b,
        output p, p_BCD, scan_data_1, scan_en_1, scan_data_0, scan_en_0,
               data_1_7seg, data_0_7seg
    );
endinterface

// File: rtl/add_tree_mult_sim.sv
// 8x8 unsigned multiplier as a 3-stage adder tree of shifted partial products,
// with a registered BCD conversion driving one static and one scanned 7-segment display.
module add_tree_mult_sim (
    input  logic                    clk_10kHz,
    input  logic                    clrn,
    input  logic                    clk_1kHz,
    add_tree_mult_sim_if.slave      io
);

    typedef enum logic [1:0] {
        SCAN_UNITS,
        SCAN_TENS,
        SCAN_HUNDREDS,
        SCAN_THOUSANDS
    } scan_t;

    logic [15:0] pp [8];
    logic [15:0] s1 [4];
    logic [15:0] s2 [2];
    logic [15:0] p_q;
    logic [19:0] bcd_next;
    logic [19:0] p_bcd_q;
    logic        en_1_q;
    logic        strobe_meta;
    logic        strobe_sync;
    logic        strobe_prev;
    logic        strobe_rise;
    scan_t       scan_q;
    scan_t       scan_next;
    logic [3:0]  scan_en_0;
    logic [3:0]  scan_data_0;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            pp[i] = io.b[i] ? ({8'h00, io.a} << i) : '0;
        end
    end

    always_ff @(posedge clk_10kHz or negedge clrn) begin
        if (!clrn) begin
            for (int unsigned i = 0; i < 4; i++) s1[i] <= '0;
            for (int unsigned i = 0; i < 2; i++) s2[i] <= '0;
            p_q     <= '0;
            p_bcd_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) s1[i] <= pp[2*i] + pp[2*i+1];
            for (int unsigned i = 0; i < 2; i++) s2[i] <= s1[2*i] + s1[2*i+1];
            p_q     <= s2[0] + s2[1];
            p_bcd_q <= bcd_next;
        end
    end

    // Shift-add-3: correct every digit that would overflow before shifting in the next bit.
    always_comb begin
        bcd_next = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned d = 0; d < 5; d++) begin
                if (bcd_next[4*d +: 4] >= 4'd5)
                    bcd_next[4*d +: 4] = bcd_next[4*d +: 4] + 4'd3;
            end
            bcd_next = {bcd_next[18:0], p_q[15 - i]};
        end
    end

    always_ff @(posedge clk_10kHz or negedge clrn) begin
        if (!clrn) begin
            en_1_q      <= 1'b0;
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
            strobe_prev <= 1'b0;
            scan_q      <= SCAN_UNITS;
        end else begin
            en_1_q      <= 1'b1;
            strobe_meta <= clk_1kHz;
            strobe_sync <= strobe_meta;
            strobe_prev <= strobe_sync;
            scan_q      <= scan_next;
        end
    end

    assign strobe_rise = strobe_sync & ~strobe_prev;

    always_comb begin
        scan_next   = scan_q;
        scan_en_0   = 4'b0001;
        scan_data_0 = p_bcd_q[3:0];
        case (scan_q)
            SCAN_UNITS: begin
                if (strobe_rise) scan_next = SCAN_TENS;
            end
            SCAN_TENS: begin
                if (strobe_rise) scan_next = SCAN_HUNDREDS;
                scan_en_0   = 4'b0010;
                scan_data_0 = p_bcd_q[7:4];
            end
            SCAN_HUNDREDS: begin
                if (strobe_rise) scan_next = SCAN_THOUSANDS;
                scan_en_0   = 4'b0100;
                scan_data_0 = p_bcd_q[11:8];
            end
            default: begin
                if (strobe_rise) scan_next = SCAN_UNITS;
                scan_en_0   = 4'b1000;
                scan_data_0 = p_bcd_q[15:12];
            end
        endcase
    end

    assign io.p           = p_q;
    assign io.p_BCD       = p_bcd_q;
    assign io.scan_data_1 = p_bcd_q[19:16];
    assign io.scan_en_1   = en_1_q;
    assign io.scan_data_0 = scan_data_0;
    assign io.scan_en_0   = scan_en_0;
    assign io.data_1_7seg = seg7(p_bcd_q[19:16]);
    assign io.data_0_7seg = seg7(scan_data_0);

endmodule

// File: tb/tb_add_tree_mult_sim.sv
// Self-checking bench for add_tree_mult_sim: scoreboarded product/BCD latency,
// display scanning, segment decode and reset behaviour.
module tb_add_tree_mult_sim;

    logic clk_10kHz = 1'b0;
    logic clrn      = 1'b0;
    logic clk_1kHz  = 1'b0;

    always #50 clk_10kHz = ~clk_10kHz;

    add_tree_mult_sim_if io ();

    add_tree_mult_sim dut (
        .clk_10kHz (clk_10kHz),
        .clrn      (clrn),
        .clk_1kHz  (clk_1kHz),
        .io        (io.slave)
    );

    typedef struct {
        int          due;
        logic [15:0] p;
        logic [19:0] bcd;
    } exp_t;

    exp_t p_q[$];
    exp_t bcd_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int idx    = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always @(posedge clk_10kHz) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] to_bcd(input int v);
        return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic drive_op(input logic [7:0] x, input logic [7:0] y);
        int v;
        @(negedge clk_10kHz);
        io.a = x;
        io.b = y;
        v = int'(x) * int'(y);
        p_q.push_back('{cyc + 3, 16'(v), to_bcd(v)});
        bcd_q.push_back('{cyc + 4, 16'(v), to_bcd(v)});
    endtask

    task automatic pulse_strobe();
        @(negedge clk_10kHz);
        clk_1kHz = 1'b1;
        repeat (3) @(negedge clk_10kHz);
        clk_1kHz = 1'b0;
        repeat (3) @(negedge clk_10kHz);
        idx = (idx + 1) % 4;
    endtask

    task automatic test_reset();
        io.a = '0;
        io.b = '0;
        clrn = 1'b0;
        repeat (2) @(negedge clk_10kHz);
        checks++;
        if (io.p !== 16'h0 || io.p_BCD !== 20'h0) begin
            errors++;
            $display("FAIL reset_pipe: p=%h p_BCD=%h, required 0/0", io.p, io.p_BCD);
        end
        checks++;
        if (io.scan_en_0 !== 4'b0001 || io.scan_data_0 !== 4'h0 || io.scan_data_1 !== 4'h0) begin
            errors++;
            $display("FAIL reset_scan: en0=%b d0=%h d1=%h, required 0001/0/0",
                     io.scan_en_0, io.scan_data_0, io.scan_data_1);
        end
        checks++;
        if (io.data_0_7seg !== 7'h3F || io.data_1_7seg !== 7'h3F || io.scan_en_1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_seg: seg0=%h seg1=%h en1=%b, required 3F/3F/0",
                     io.data_0_7seg, io.data_1_7seg, io.scan_en_1);
        end
        clrn = 1'b1;
        @(posedge clk_10kHz);
        #1;
        checks++;
        if (io.scan_en_1 !== 1'b1) begin
            errors++;
            $display("FAIL en1_after_reset: got %b, required 1", io.scan_en_1);
        end
    endtask

    task automatic test_products();
        logic [7:0] ta [9] = '{8'd1, 8'd3, 8'd10, 8'd125, 8'd150, 8'd254, 8'd255, 8'd0, 8'd255};
        logic [7:0] tb [9] = '{8'd1, 8'd3, 8'd20, 8'd3, 8'd40, 8'd11, 8'd255, 8'd255, 8'd0};
        exp_t e;
        for (int k = 0; k < 9 + 6; k++) begin
            if (k < 9) drive_op(ta[k], tb[k]);
            else @(negedge clk_10kHz);
            @(posedge clk_10kHz);
            #1;
            while (p_q.size() > 0 && p_q[0].due <= cyc) begin
                e = p_q.pop_front();
                checks++;
                if (io.p !== e.p || e.due != cyc) begin
                    errors++;
                    $display("FAIL prod_p: got %h at cycle %0d, required %h at cycle %0d",
                             io.p, cyc, e.p, e.due);
                end
            end
            while (bcd_q.size() > 0 && bcd_q[0].due <= cyc) begin
                e = bcd_q.pop_front();
                checks++;
                if (io.p_BCD !== e.bcd || e.due != cyc) begin
                    errors++;
                    $display("FAIL prod_bcd: got %h at cycle %0d, required %h at cycle %0d",
                             io.p_BCD, cyc, e.bcd, e.due);
                end
            end
        end
        checks++;
        if (p_q.size() != 0 || bcd_q.size() != 0) begin
            errors++;
            $display("FAIL prod_drain: %0d/%0d entries left, required 0/0", p_q.size(), bcd_q.size());
            p_q.delete();
            bcd_q.delete();
        end
    endtask

    task automatic test_scan();
        logic [19:0] exp_bcd;
        logic [3:0]  dig;
        logic [3:0]  en;
        @(negedge clk_10kHz);
        io.a = 8'd10;
        io.b = 8'd20;
        exp_bcd = to_bcd(200);
        repeat (6) @(negedge clk_10kHz);
        checks++;
        if (io.p !== 16'd200 || io.p_BCD !== exp_bcd) begin
            errors++;
            $display("FAIL scan_value: p=%0d p_BCD=%h, required 200/%h", io.p, io.p_BCD, exp_bcd);
        end
        checks++;
        if (io.scan_data_1 !== 4'h0 || io.data_1_7seg !== 7'h3F) begin
            errors++;
            $display("FAIL scan_disp1: d1=%h seg1=%h, required 0/3F", io.scan_data_1, io.data_1_7seg);
        end
        for (int k = 0; k < 5; k++) begin
            en  = 4'(1 << idx);
            dig = exp_bcd[4*idx +: 4];
            checks++;
            if (io.scan_en_0 !== en || io.scan_data_0 !== dig || io.data_0_7seg !== seg_tab[dig]) begin
                errors++;
                $display("FAIL scan_step%0d: en0=%b d0=%h seg0=%h, required %b/%h/%h",
                         k, io.scan_en_0, io.scan_data_0, io.data_0_7seg, en, dig, seg_tab[dig]);
            end
            pulse_strobe();
        end
    endtask

    task automatic test_max();
        logic [19:0] exp_bcd;
        logic [3:0]  dig;
        logic [3:0]  en;
        @(negedge clk_10kHz);
        io.a = 8'd255;
        io.b = 8'd255;
        exp_bcd = to_bcd(65025);
        repeat (6) @(negedge clk_10kHz);
        checks++;
        if (io.p !== 16'hFE01 || io.p_BCD !== exp_bcd) begin
            errors++;
            $display("FAIL max_value: p=%h p_BCD=%h, required FE01/%h", io.p, io.p_BCD, exp_bcd);
        end
        checks++;
        if (io.scan_data_1 !== 4'd6 || io.data_1_7seg !== 7'h7D || io.scan_en_1 !== 1'b1) begin
            errors++;
            $display("FAIL max_disp1: d1=%h seg1=%h en1=%b, required 6/7D/1",
                     io.scan_data_1, io.data_1_7seg, io.scan_en_1);
        end
        for (int k = 0; k < 4; k++) begin
            en  = 4'(1 << idx);
            dig = exp_bcd[4*idx +: 4];
            checks++;
            if (io.scan_en_0 !== en || io.scan_data_0 !== dig || io.data_0_7seg !== seg_tab[dig]) begin
                errors++;
                $display("FAIL max_scan%0d: en0=%b d0=%h seg0=%h, required %b/%h/%h",
                         k, io.scan_en_0, io.scan_data_0, io.data_0_7seg, en, dig, seg_tab[dig]);
            end
            pulse_strobe();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] en;
        for (int k = 0; k < 40 + 6; k++) begin
            if (k < 40) drive_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            else @(negedge clk_10kHz);
            @(posedge clk_10kHz);
            #1;
            while (p_q.size() > 0 && p_q[0].due <= cyc) begin
                e = p_q.pop_front();
                checks++;
                if (io.p !== e.p || e.due != cyc) begin
                    errors++;
                    $display("FAIL b2b_p: got %h at cycle %0d, required %h at cycle %0d",
                             io.p, cyc, e.p, e.due);
                end
            end
            while (bcd_q.size() > 0 && bcd_q[0].due <= cyc) begin
                e = bcd_q.pop_front();
                checks++;
                if (io.p_BCD !== e.bcd || e.due != cyc) begin
                    errors++;
                    $display("FAIL b2b_bcd: got %h at cycle %0d, required %h at cycle %0d",
                             io.p_BCD, cyc, e.bcd, e.due);
                end
            end
        end
        checks++;
        if (p_q.size() != 0 || bcd_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d/%0d entries left, required 0/0", p_q.size(), bcd_q.size());
            p_q.delete();
            bcd_q.delete();
        end

        if (idx == 0) pulse_strobe();
        en = 4'(1 << idx);
        checks++;
        if (io.scan_en_0 !== en) begin
            errors++;
            $display("FAIL prereset_scan: en0=%b, required %b", io.scan_en_0, en);
        end
        @(posedge clk_10kHz);
        #20;
        clrn = 1'b0;
        #1;
        idx = 0;
        checks++;
        if (io.scan_en_0 !== 4'b0001 || io.p !== 16'h0 || io.p_BCD !== 20'h0 || io.scan_en_1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset: en0=%b p=%h p_BCD=%h en1=%b, required 0001/0/0/0",
                     io.scan_en_0, io.p, io.p_BCD, io.scan_en_1);
        end
        @(negedge clk_10kHz);
        clrn = 1'b1;
        @(posedge clk_10kHz);
        #1;
        checks++;
        if (io.scan_en_1 !== 1'b1 || io.scan_en_0 !== 4'b0001) begin
            errors++;
            $display("FAIL postreset: en1=%b en0=%b, required 1/0001", io.scan_en_1, io.scan_en_0);
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_scan();
        test_max();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
